// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the cpu_sequencer block (run/stall sequencer
// for the 9-bit-ISA core) and its jump-target LUT.
package seq_pkg;

    localparam int INSTR_W   = 9;
    localparam int LUT_IDX_W = 4;
    localparam int WAIT_W    = 3;

    // Reserved opcode that stops the core.
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        MEMWAIT,
        HALT
    } seq_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cpu_sequencer_jump_lut.sv
// Programmable jump-target table: LUT_DEPTH entries of PC_W bits.
// One synchronous write port, one asynchronous read port, cleared by reset.
// A write lands on the clock edge, so a read of the same index in the same
// cycle still returns the previous contents. Indices at or beyond LUT_DEPTH
// are ignored on write and read back as zero.
module jump_lut
    import seq_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [LUT_IDX_W-1:0] i_wr_idx,
    input  logic [PC_W-1:0]      i_wr_data,
    input  logic [LUT_IDX_W-1:0] i_rd_idx,
    output logic [PC_W-1:0]      o_rd_data
);

    logic [PC_W-1:0] r_mem [LUT_DEPTH];
    logic [PC_W-1:0] w_rd_data;

    // Entry storage: clear on reset, otherwise accept a write to a valid index.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                if (i_wr_en && (i_wr_idx == LUT_IDX_W'(i))) begin
                    r_mem[i] <= i_wr_data;
                end
            end
        end
    end

    // Asynchronous read; an index with no backing entry yields zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (i_rd_idx == LUT_IDX_W'(i)) begin
                w_rd_data = r_mem[i];
            end
        end
    end

    assign o_rd_data = w_rd_data;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: run/stall sequencer for the 9-bit-ISA core.
// Owns the PC and the jump-target LUT, drives the instruction ROM address,
// turns decoder requests into a single commit strobe per retired instruction
// and inserts data-memory wait states.
// Optional feature: define SEQ_PERF_CNT_EN to build the cycle/instruction
// performance counters; without it both counter ports are tied to zero.
module cpu_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 pc_jmp_en,
    input  logic [LUT_IDX_W-1:0] lut_ptr,
    input  logic                 mem_op,
    input  logic                 lut_wr_en,
    input  logic [LUT_IDX_W-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic [PC_W-1:0]      pc,
    output logic                 commit_en,
    output logic                 stall,
    output logic                 done,
    output logic [15:0]          cycle_cnt,
    output logic [15:0]          instr_cnt
);

    // A memory op spends one cycle in RUN and MEM_LAT-1 cycles in MEMWAIT
    // before the commit cycle, so the wait counter is loaded with MEM_LAT-1.
    localparam bit                MEM_WAIT_EN = (MEM_LAT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LOAD   = (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_next_pc;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_lut_target;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_next_wait_cnt;
    logic              w_commit;
    logic              w_stall;
    logic              w_start_run;

    jump_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_jump_lut (
        .clk       (clk),
        .i_reset   (reset),
        .i_wr_en   (lut_wr_en),
        .i_wr_idx  (lut_wr_idx),
        .i_wr_data (lut_wr_data),
        .i_rd_idx  (lut_ptr),
        .o_rd_data (w_lut_target)
    );

    // Sequential increment; wraps modulo 2**PC_W by truncation.
    assign w_pc_inc = r_pc + PC_W'(1);

    // State, PC and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // Next-state, next-PC and strobe decode. stall marks every cycle a memory
    // op occupies without retiring (the RUN cycle that detects it plus the
    // non-final MEMWAIT cycles); the final MEMWAIT cycle commits instead.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_wait_cnt = r_wait_cnt;
        w_commit        = 1'b0;
        w_stall         = 1'b0;
        w_start_run     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_pc = '0;
                if (start) begin
                    w_next_state = RUN;
                    w_start_run  = 1'b1;
                end
            end
            RUN: begin
                if (instr == HALT_INSTR) begin
                    w_next_state = HALT;
                end else if (mem_op && MEM_WAIT_EN) begin
                    w_stall         = 1'b1;
                    w_next_wait_cnt = WAIT_LOAD;
                    w_next_state    = MEMWAIT;
                end else begin
                    w_commit  = 1'b1;
                    w_next_pc = pc_jmp_en ? w_lut_target : w_pc_inc;
                end
            end
            MEMWAIT: begin
                // Memory ops always fall through; pc_jmp_en is not consulted.
                if (r_wait_cnt == '0) begin
                    w_commit     = 1'b1;
                    w_next_pc    = w_pc_inc;
                    w_next_state = RUN;
                end else begin
                    w_stall         = 1'b1;
                    w_next_wait_cnt = r_wait_cnt - WAIT_W'(1);
                end
            end
            HALT: begin
                if (start) begin
                    w_next_pc    = '0;
                    w_next_state = RUN;
                    w_start_run  = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_pc    = '0;
            end
        endcase
    end

    assign pc        = r_pc;
    assign commit_en = w_commit;
    assign stall     = w_stall;
    assign done      = (r_state == HALT);

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_instr_cnt;

    // Saturating perf counters: count active cycles and retirements, freeze
    // in HALT/IDLE, restart from zero whenever a new program is launched.
    always_ff @(posedge clk) begin
        if (reset || w_start_run) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if ((r_state == RUN) || (r_state == MEMWAIT)) begin
                r_cycle_cnt <= sat_inc16(r_cycle_cnt);
            end
            if (w_commit) begin
                r_instr_cnt <= sat_inc16(r_instr_cnt);
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: ROM and decoder modelled in the bench,
// expected retirements pushed to a scoreboard by a program-level model,
// popped and compared by an independent monitor.
module tb_cpu_sequencer;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int MEM_LAT   = 2;
`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [8:0]      instr;
    logic            pc_jmp_en;
    logic [3:0]      lut_ptr;
    logic            mem_op;
    logic            lut_wr_en = 1'b0;
    logic [3:0]      lut_wr_idx = '0;
    logic [PC_W-1:0] lut_wr_data = '0;
    logic [PC_W-1:0] pc;
    logic            commit_en;
    logic            stall;
    logic            done;
    logic [15:0]     cycle_cnt;
    logic [15:0]     instr_cnt;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH),
        .MEM_LAT   (MEM_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .pc_jmp_en   (pc_jmp_en),
        .lut_ptr     (lut_ptr),
        .mem_op      (mem_op),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .pc          (pc),
        .commit_en   (commit_en),
        .stall       (stall),
        .done        (done),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    // Bench ISA: 1FF halt, 10xxxxxxx memory op (bit 6 also raises pc_jmp_en,
    // which must be ignored), 11xxxxxxx jump via LUT[instr[3:0]], 0xxxxxxxx ALU.
    logic [8:0] rom [1024];
    assign instr     = rom[pc];
    assign mem_op    = (instr[8:7] == 2'b10);
    assign pc_jmp_en = (instr[8:7] == 2'b11) || ((instr[8:7] == 2'b10) && instr[6]);
    assign lut_ptr   = instr[3:0];

    typedef struct { logic [9:0] pc; int wt; } commit_t;
    typedef struct { logic [9:0] pc; int cyc; int icnt; } halt_t;

    commit_t    exp_q[$];
    halt_t      done_q[$];
    logic [9:0] lut_m [16];
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitor: pops one expectation per commit and per HALT entry.
    int      stall_run = 0;
    bit      done_prev = 1'b0;
    commit_t mon_c;
    halt_t   mon_h;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                stall_run = 0;
                done_prev = 1'b0;
            end else begin
                if (commit_en) begin
                    chk("commit_stall_low", stall, 0);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_commit: pc=0x%0h with no retirement expected", pc);
                    end else begin
                        mon_c = exp_q.pop_front();
                        chk("commit_pc", pc, mon_c.pc);
                        chk("stall_cycles", stall_run, mon_c.wt);
                    end
                    stall_run = 0;
                end else if (stall) begin
                    stall_run++;
                end
                if (done && !done_prev) begin
                    if (done_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_halt: pc=0x%0h with no halt expected", pc);
                    end else begin
                        mon_h = done_q.pop_front();
                        chk("halt_pc", pc, mon_h.pc);
                        chk("halt_cycle_cnt", cycle_cnt, mon_h.cyc);
                        chk("halt_instr_cnt", instr_cnt, mon_h.icnt);
                    end
                end
                done_prev = done;
            end
        end
    end

    // Program-level reference: walks the ROM, applying one optional LUT write
    // right after retirement number mid_ord.
    task automatic model(input int mid_ord, input logic [3:0] mid_idx, input logic [9:0] mid_data,
                         input bit push, output bit ok, output halt_t h, output int ncyc);
        logic [9:0] lut_l [16];
        logic [9:0] p;
        logic [8:0] w;
        int         ord;
        commit_t    c;
        lut_l = lut_m;
        p = '0; ord = 0; ncyc = 0; ok = 1'b0;
        while (ord < 100) begin
            w = rom[p];
            if (w == 9'h1FF) begin
                ncyc++;
                ok = 1'b1;
                break;
            end
            c.pc = p;
            if (w[8:7] == 2'b10) begin
                c.wt = MEM_LAT;
                ncyc += MEM_LAT + 1;
                p = p + 10'd1;
            end else begin
                c.wt = 0;
                ncyc += 1;
                p = (w[8:7] == 2'b11) ? lut_l[w[3:0]] : p + 10'd1;
            end
            if (push) exp_q.push_back(c);
            if (ord == mid_ord) lut_l[mid_idx] = mid_data;
            ord++;
        end
        h.pc   = p;
        h.cyc  = PERF ? ((ncyc > 65535) ? 65535 : ncyc) : 0;
        h.icnt = PERF ? ord : 0;
        if (push) begin
            done_q.push_back(h);
            lut_m = lut_l;
        end
    endtask

    task automatic lut_write(input logic [3:0] idx, input logic [9:0] data);
        @(negedge clk);
        lut_wr_en = 1'b1; lut_wr_idx = idx; lut_wr_data = data;
        @(negedge clk);
        lut_wr_en = 1'b0;
        lut_m[idx] = data;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    endtask

    task automatic rom_random();
        int r;
        for (int i = 0; i < 1024; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       rom[i] = 9'h1FF;
            else if (r < 28) rom[i] = {2'b10, 7'($urandom_range(0, 127))};
            else if (r < 43) rom[i] = {2'b11, 7'($urandom_range(0, 126))};
            else             rom[i] = {1'b0, 8'($urandom_range(0, 255))};
        end
    endtask

    // Launches the ROM program from IDLE/HALT and waits (bounded) for HALT.
    task automatic run_case(input int mid_ord, input logic [3:0] mid_idx, input logic [9:0] mid_data,
                            input string tag);
        bit    ok;
        halt_t h;
        int    ncyc;
        int    cyc;
        int    commits;
        model(mid_ord, mid_idx, mid_data, 1'b0, ok, h, ncyc);
        if (!ok) begin
            n_chk++;
            $display("FAIL %s_setup: program never halts (got no halt, expected one)", tag);
            return;
        end
        model(mid_ord, mid_idx, mid_data, 1'b1, ok, h, ncyc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_first_pc"}, pc, 0);
        chk({tag, "_cycle_cnt_clr"}, cycle_cnt, 0);
        chk({tag, "_instr_cnt_clr"}, instr_cnt, 0);
        cyc = 1; commits = 0;
        while (!done && cyc <= ncyc + 20) begin
            lut_wr_en = 1'b0;
            if (commit_en) begin
                if (commits == mid_ord) begin
                    lut_wr_en = 1'b1; lut_wr_idx = mid_idx; lut_wr_data = mid_data;
                end
                commits++;
            end
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; lut_wr_en = 1'b0;
        chk({tag, "_done_cycle"}, cyc, ncyc + 1);
        repeat (3) @(negedge clk);
        chk({tag, "_hold_done"}, done, 1);
        chk({tag, "_hold_pc"}, pc, h.pc);
        chk({tag, "_hold_cycle_cnt"}, cycle_cnt, h.cyc);
        chk({tag, "_hold_instr_cnt"}, instr_cnt, h.icnt);
    endtask

    task automatic random_case(input int k);
        bit         ok;
        halt_t      h;
        int         ncyc;
        int         mo;
        logic [3:0] mi;
        logic [9:0] md;
        for (int i = 0; i < 16; i++) lut_write(4'(i), 10'($urandom_range(0, 1023)));
        mo = $urandom_range(0, 3);
        mi = 4'($urandom_range(0, 15));
        md = 10'($urandom_range(0, 1023));
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            rom_random();
            model(mo, mi, md, 1'b0, ok, h, ncyc);
        end
        run_case(mo, mi, md, $sformatf("rnd%0d", k));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int      stalls;
        commit_t c;
        for (int i = 0; i < 16; i++) lut_m[i] = '0;
        rom_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_pc", pc, 0);
        chk("reset_commit", commit_en, 0);
        chk("reset_stall", stall, 0);
        chk("reset_done", done, 0);
        chk("reset_cycle_cnt", cycle_cnt, 0);
        chk("reset_instr_cnt", instr_cnt, 0);

        // Three ALU ops then halt.
        rom_clear();
        rom[3] = 9'h1FF;
        run_case(-1, 4'd0, 10'd0, "alu3");

        // Jump through LUT[5].
        lut_write(4'd5, 10'h020);
        rom_clear();
        rom[4] = 9'h185; rom[10'h020] = 9'h1FF;
        run_case(-1, 4'd0, 10'd0, "jump");

        // Memory op at pc 7; its jump bit must not redirect.
        rom_clear();
        rom[7] = 9'h145; rom[8] = 9'h1FF;
        run_case(-1, 4'd0, 10'd0, "memop");

        // LUT[3] rewritten in the same cycle the jump reads it.
        lut_write(4'd3, 10'h010);
        rom_clear();
        rom[1] = 9'h183; rom[10'h010] = 9'h183; rom[10'h055] = 9'h1FF;
        run_case(1, 4'd3, 10'h055, "lut_same_cycle");

        // PC wraps from 0x3FF to 0.
        lut_write(4'd1, 10'h3FE);
        rom_clear();
        rom[0] = 9'h181; rom[5] = 9'h1FF;
        run_case(0, 4'd1, 10'h005, "pc_wrap");

        // Reset while in MEMWAIT abandons the memory op.
        lut_write(4'd7, 10'h123);
        rom_clear();
        rom[1] = 9'h100; rom[2] = 9'h1FF;
        c.pc = 10'd0; c.wt = 0;
        exp_q.push_back(c);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        stalls = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (stall) begin
                stalls++;
                if (stalls == 2) break;
            end
            @(negedge clk);
        end
        chk("rst_reached_memwait", stalls, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) lut_m[i] = '0;
        chk("rst_mid_pc", pc, 0);
        chk("rst_mid_commit", commit_en, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_cycle_cnt", cycle_cnt, 0);
        chk("rst_mid_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("rst_idle_pc", pc, 0);

        // LUT contents were cleared by that reset.
        rom_clear();
        rom[0] = 9'h187; rom[9] = 9'h1FF;
        run_case(0, 4'd7, 10'h009, "lut_reset");

        for (int k = 0; k < 6; k++) random_case(k);

        repeat (2) @(negedge clk);
        chk("scoreboard_commits_drained", exp_q.size(), 0);
        chk("scoreboard_halts_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
